prbs5_checker: RTL and testbench
================================

PRBS5_CHECKER -- requirements
Module: prbs5_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, consecutive matching words needed after seeding to declare lock (1..15).
REQ-002 SHALL have parameter LOSS_CNT, default 3, consecutive mismatching words in LOCKED that force loss of lock (1..15).
REQ-003 SHALL have parameter CNT_W, default 16, width of the error and word counters.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_data carries a word this cycle.
REQ-007 SHALL have port in_data  input  8  received 8-bit word from the 5-bit Fibonacci random generator.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of err_count and word_count.
REQ-009 SHALL have port locked  output  1  checker is in LOCKED.
REQ-010 SHALL have port err_pulse  output  1  one-cycle pulse per mismatched word while LOCKED.
REQ-011 SHALL have port err_count  output  CNT_W  saturating count of mismatched words while LOCKED.
REQ-012 SHALL have port word_count  output  CNT_W  saturating count of words checked while LOCKED.
REQ-013 SHALL have port state  output  2  FSM state: 0 HUNT, 1 CONFIRM, 2 LOCKED.

Function
REQ-014 SHALL use a predictor P(d) for 5-bit state d: n7=d4^d1, n6=d3^d0, n5=d2^n7, n4=d1^n6, n3=d0^n5, n2=n7^n4, n1=n6^n3, n0=n5^n2; next state = {d3,d2,d1,d0,n7}.
REQ-015 SHALL recover the state from a word b as d2=b5^b7, d1=b4^b6, d0=b3^b5, d3=b6^d0, d4=b7^d1; the expected state for the following word is {d3,d2,d1,d0,b7}.
REQ-016 SHALL act only on cycles with in_valid=1; with in_valid=0 all state and counters hold and err_pulse is 0.
REQ-017 HUNT: on a valid word, recover the state; if the recovered state is 5'h00, stay in HUNT; otherwise load the expected state, clear the match count, and go to CONFIRM.
REQ-018 CONFIRM: on a valid word equal to P(expected state), increment the match count and advance the expected state; when the match count reaches LOCK_CNT, go to LOCKED.
REQ-019 CONFIRM mismatch: re-seed from the mismatched word per REQ-015, clear the match count, and stay in CONFIRM (go to HUNT if the recovered state is 0); no error is counted.
REQ-020 LOCKED: every valid word increments word_count and advances the expected state from the prediction, never from received data, so bit errors do not propagate.
REQ-021 LOCKED match: clear the miss count.
REQ-022 LOCKED mismatch: assert err_pulse the next cycle, increment err_count, and increment the miss count; when the miss count reaches LOSS_CNT, go to HUNT.
REQ-023 locked and state SHALL be registered and update the cycle after the deciding word.
REQ-024 Counters SHALL saturate at all-ones, with no wrap-around.
REQ-025 clr_cnt SHALL take priority over increment: a clear coinciding with an error or word yields count 0, and err_pulse still fires.
REQ-026 The 31-word sequence period SHALL wrap naturally through the predictor, with no special handling.

Reset
REQ-027 While rst_n=0, the block SHALL be in HUNT with state=0, locked=0, err_pulse=0, err_count=0, word_count=0, expected state 5'h1F, and match and miss counts 0.
REQ-028 Reset asserted mid-operation, including in LOCKED, SHALL return the block to REQ-027 values immediately, without waiting for clk.

Verification
REQ-029 Feed the seed-0x1F stream 0x34, 0x69, 0xD2, ... one word per cycle -> locked=1 the cycle after word 5 (LOCK_CNT=4); err_count=0.
REQ-030 While LOCKED, flip bit 0 of one word -> a single err_pulse, err_count=1, locked stays 1, and the next correct words match.
REQ-031 While LOCKED, corrupt 3 consecutive words -> err_count=3, locked=0 and state=0 the cycle after the third word; a clean stream relocks after 5 words.
REQ-032 Input words 0x00 in HUNT -> stays in HUNT; word 0xFF then a clean stream -> CONFIRM re-seeds on mismatch and locks, with no errors counted.
REQ-033 Interleave in_valid=0 gaps in a clean locked stream -> no errors; word_count equals the number of valid words.
REQ-034 Assert rst_n=0 mid-LOCKED, then clr_cnt coinciding with an error -> immediate reset values; after the clear, err_count=0 and err_pulse=1.

Source files
------------

// File: rtl/prbs5_checker.sv
// prbs5_checker: lock/track checker for an 8-bit-per-word stream produced by
// a 5-bit Fibonacci random generator. Seeds from received data, confirms over
// LOCK_CNT words, then free-runs its own prediction and counts word errors.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HUNT (0)   | waiting for a word whose recovered generator state is nonzero
// CONFIRM (1)| seeded; counting consecutive predicted-word matches
// LOCKED (2) | free-running prediction; counting words, errors and misses
module prbs5_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TC = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TC = 4'(LOSS_CNT);

  // Eight output bits the generator emits starting from state d.
  function automatic logic [7:0] pred_word(input logic [4:0] d);
    logic n7, n6, n5, n4, n3, n2, n1, n0;
    n7 = d[4] ^ d[1];
    n6 = d[3] ^ d[0];
    n5 = d[2] ^ n7;
    n4 = d[1] ^ n6;
    n3 = d[0] ^ n5;
    n2 = n7 ^ n4;
    n1 = n6 ^ n3;
    n0 = n5 ^ n2;
    return {n7, n6, n5, n4, n3, n2, n1, n0};
  endfunction

  // Generator state that would have produced word b (uses the top five bits).
  function automatic logic [4:0] recover(input logic [7:0] b);
    logic r4, r3, r2, r1, r0;
    r2 = b[5] ^ b[7];
    r1 = b[4] ^ b[6];
    r0 = b[3] ^ b[5];
    r3 = b[6] ^ r0;
    r4 = b[7] ^ r1;
    return {r4, r3, r2, r1, r0};
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       exp_q, exp_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             pulse_q, pulse_d;
  logic             locked_q, locked_d;

  logic [7:0]       pred;
  logic [4:0]       rec;
  logic             hit;
  logic [4:0]       seed;

  assign pred = pred_word(exp_q);
  assign rec  = recover(in_data);
  assign hit  = (in_data == pred);
  assign seed = {rec[3:0], in_data[7]};

  // State register and all tracking/counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      exp_q      <= 5'h1F;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
      pulse_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
      pulse_q    <= pulse_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state, prediction advance and counter updates.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    pulse_d    = 1'b0;

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (rec != 5'h00) begin
            exp_d   = seed;
            match_d = 4'd0;
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (hit) begin
            match_d = match_q + 4'd1;
            exp_d   = {exp_q[3:0], pred[7]};
            if (match_q + 4'd1 == LOCK_TC) begin
              state_d = ST_LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            match_d = 4'd0;
            if (rec == 5'h00) begin
              state_d = ST_HUNT;
            end else begin
              exp_d = seed;
            end
          end
        end
        ST_LOCKED: begin
          // Advance from our own prediction so a corrupted word cannot
          // poison the words that follow it.
          exp_d = {exp_q[3:0], pred[7]};
          if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + CNT_W'(1);
          if (hit) begin
            miss_d = 4'd0;
          end else begin
            pulse_d = 1'b1;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOSS_TC) begin
              state_d = ST_HUNT;
              miss_d  = 4'd0;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          match_d = 4'd0;
          miss_d  = 4'd0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  assign state      = state_q;
  assign locked     = locked_q;
  assign err_pulse  = pulse_q;
  assign err_count  = err_cnt_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_prbs5_checker.sv
// Bench for prbs5_checker. The reference model views the stream as positions
// in the 31-bit maximal-length bit sequence x[m] = x[m-5] ^ x[m-2].
module tb_prbs5_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int CNT_W    = 5;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] word_count;
  logic [1:0]       state;

  prbs5_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .word_count(word_count), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit seq[31];

  int m_st, m_idx, m_match, m_miss, m_ec, m_wc;
  bit m_ep;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         c;
    int         st;
    bit         lk;
    bit         ep;
    int         ec;
    int         wc;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word_at(input int j);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = seq[(j + 5 + i) % 31];
    return r;
  endfunction

  function automatic logic [7:0] w(input int k);
    return word_at(k % 31);
  endfunction

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_match = 0; m_miss = 0; m_ec = 0; m_wc = 0; m_ep = 0;
  endtask

  // Seed: find the sequence position whose first five emitted bits match.
  task automatic model_seed(input logic [7:0] d);
    logic [7:0] cand;
    logic [4:0] top;
    top = d[7:3];
    m_match = 0;
    if (top == 5'd0) begin
      m_st = 0;
    end else begin
      for (int j = 0; j < 31; j++) begin
        cand = word_at(j);
        if (cand[7:3] == top) m_idx = (j + 1) % 31;
      end
      m_st = 1;
    end
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit c);
    m_ep = 0;
    if (v) begin
      if (m_st == 0) begin
        model_seed(d);
      end else if (m_st == 1) begin
        if (d == word_at(m_idx)) begin
          m_match++;
          m_idx = (m_idx + 1) % 31;
          if (m_match == LOCK_CNT) begin m_st = 2; m_miss = 0; end
        end else begin
          model_seed(d);
        end
      end else begin
        if (m_wc < MAXC) m_wc++;
        if (d != word_at(m_idx)) begin
          m_ep = 1;
          if (m_ec < MAXC) m_ec++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin m_st = 0; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
        m_idx = (m_idx + 1) % 31;
      end
    end
    if (c) begin m_ec = 0; m_wc = 0; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_st));
    chk({tag, ".locked"}, 32'(locked), 32'(m_st == 2));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_ep));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_ec));
    chk({tag, ".word_count"}, 32'(word_count), 32'(m_wc));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit c, input string tag);
    @(negedge clk);
    in_valid = v; in_data = d; clr_cnt = c;
    @(posedge clk);
    model_update(v, d, c);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_from(input int k0);
    for (int k = 0; k < LOCK_CNT + 1; k++) step(1'b1, w(k0 + k), 1'b0, "lock");
  endtask

  initial begin
    int p;
    int nvalid;
    int r;
    logic [7:0] dd;

    for (int i = 0; i < 5; i++) seq[i] = 1'b1;
    for (int m = 5; m < 31; m++) seq[m] = seq[m-5] ^ seq[m-2];

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    model_reset();
    chk("w0_is_34", 32'(w(0)), 32'h34);
    chk("w1_is_69", 32'(w(1)), 32'h69);
    chk("w2_is_D2", 32'(w(2)), 32'hD2);
    do_reset();

    // Directed vector table: lock, single error, loss, relock, clear.
    tbl[0]  = '{1'b1, w(0),          1'b0, 1, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, w(1),          1'b0, 1, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, w(2),          1'b0, 1, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, w(3),          1'b0, 1, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, w(4),          1'b0, 2, 1'b1, 1'b0, 0, 0};
    tbl[5]  = '{1'b1, w(5),          1'b0, 2, 1'b1, 1'b0, 0, 1};
    tbl[6]  = '{1'b1, w(6) ^ 8'h01,  1'b0, 2, 1'b1, 1'b1, 1, 2};
    tbl[7]  = '{1'b1, w(7),          1'b0, 2, 1'b1, 1'b0, 1, 3};
    tbl[8]  = '{1'b0, 8'h00,         1'b0, 2, 1'b1, 1'b0, 1, 3};
    tbl[9]  = '{1'b1, w(8),          1'b0, 2, 1'b1, 1'b0, 1, 4};
    tbl[10] = '{1'b1, w(9) ^ 8'hFF,  1'b0, 2, 1'b1, 1'b1, 2, 5};
    tbl[11] = '{1'b1, w(10) ^ 8'h10, 1'b0, 2, 1'b1, 1'b1, 3, 6};
    tbl[12] = '{1'b1, w(11) ^ 8'h01, 1'b0, 0, 1'b0, 1'b1, 4, 7};
    tbl[13] = '{1'b1, w(12),         1'b0, 1, 1'b0, 1'b0, 4, 7};
    tbl[14] = '{1'b1, w(13),         1'b0, 1, 1'b0, 1'b0, 4, 7};
    tbl[15] = '{1'b1, w(14),         1'b0, 1, 1'b0, 1'b0, 4, 7};
    tbl[16] = '{1'b1, w(15),         1'b0, 1, 1'b0, 1'b0, 4, 7};
    tbl[17] = '{1'b1, w(16),         1'b0, 2, 1'b1, 1'b0, 4, 7};
    tbl[18] = '{1'b1, w(17),         1'b1, 2, 1'b1, 1'b0, 0, 0};
    tbl[19] = '{1'b1, w(18) ^ 8'h80, 1'b1, 2, 1'b1, 1'b1, 0, 0};
    tbl[20] = '{1'b1, w(19),         1'b0, 2, 1'b1, 1'b0, 0, 1};
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, "tbl_model");
      chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("tbl%0d.err_pulse", i), 32'(err_pulse), 32'(tbl[i].ep));
      chk($sformatf("tbl%0d.err_count", i), 32'(err_count), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d.word_count", i), 32'(word_count), 32'(tbl[i].wc));
    end

    // Asynchronous reset in LOCKED takes effect without a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.state", 32'(state), 32'd0);
    chk("async_rst.locked", 32'(locked), 32'd0);
    chk("async_rst.word_count", 32'(word_count), 32'd0);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero words never seed; 0xFF seeds, then the clean stream re-seeds.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0, "zero_hunt");
    chk("zero_hunt.state", 32'(state), 32'd0);
    step(1'b1, 8'hFF, 1'b0, "ff_seed");
    chk("ff_seed.state", 32'(state), 32'd1);
    step(1'b1, w(0), 1'b0, "reseed");
    chk("reseed.state", 32'(state), 32'd1);
    for (int k = 1; k < 4; k++) step(1'b1, w(k), 1'b0, "reseed_run");
    chk("reseed_run.not_yet", 32'(locked), 32'd0);
    step(1'b1, w(4), 1'b0, "reseed_lock");
    chk("reseed_lock.locked", 32'(locked), 32'd1);
    chk("reseed_lock.err_count", 32'(err_count), 32'd0);

    // Gaps in a locked stream; wrap through the 31-word period.
    step(1'b0, 8'h00, 1'b1, "gap_clr");
    p = 5; nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      if ((i % 3) == 1) begin
        step(1'b0, 8'hA5, 1'b0, "gap");
      end else begin
        step(1'b1, w(p), 1'b0, "gap");
        p++; nvalid++;
      end
    end
    chk("gap.word_count", 32'(word_count), 32'(nvalid));
    chk("gap.err_count", 32'(err_count), 32'd0);
    chk("gap.locked", 32'(locked), 32'd1);

    // Saturation of both counters.
    for (int i = 0; i < 10; i++) begin step(1'b1, w(p), 1'b0, "sat_w"); p++; end
    chk("sat.word_count", 32'(word_count), 32'(MAXC));
    for (int i = 0; i < 34; i++) begin
      step(1'b1, w(p) ^ 8'h04, 1'b0, "sat_e"); p++;
      step(1'b1, w(p), 1'b0, "sat_e"); p++;
    end
    chk("sat.err_count", 32'(err_count), 32'(MAXC));
    chk("sat.locked", 32'(locked), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    p = 0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        step(1'b0, 8'($urandom), 1'b0, "rnd");
      end else if (r < 15) begin
        dd = 8'($urandom_range(1, 255));
        step(1'b1, w(p) ^ dd, 1'b0, "rnd"); p++;
      end else if (r < 17) begin
        step(1'b1, 8'($urandom), 1'b0, "rnd");
      end else if (r < 19) begin
        step(1'b1, w(p), 1'b1, "rnd"); p++;
      end else if (r < 20) begin
        p = int'($urandom_range(0, 30));
        step(1'b1, w(p), 1'b0, "rnd"); p++;
      end else if (r < 21) begin
        for (int b = 0; b < LOSS_CNT; b++) begin
          step(1'b1, w(p) ^ 8'h81, 1'b0, "rnd"); p++;
        end
      end else begin
        step(1'b1, w(p), 1'b0, "rnd"); p++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
